// File: rtl/data_memory_responder.sv
// Load/store responder for the MA stage: services one request against a word array
// after LATENCY cycles in ACCESS, with RV32 lane selection, extension and byte merging.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  func3,
  output logic [31:0] read_data,
  output logic        busy_wait,
  output logic        access_error
);

  // state  | meaning
  // IDLE   | waiting for mem_read/mem_write
  // ACCESS | request latched, counting down the latency
  // DONE   | result visible for one cycle, pipeline released
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state;
  logic [3:0]       count;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       func3_q;
  logic             write_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             request;
  logic             commit;
  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             aligned;
  logic             error;
  logic [31:0]      word;
  logic [31:0]      shifted;
  logic [15:0]      sel_half;
  logic [31:0]      load_val;
  logic [31:0]      lane_data;
  logic [3:0]       byte_en;
  logic [31:0]      merged;

  assign request   = mem_read | mem_write;
  assign commit    = (state == S_ACCESS) && (count == 4'd0);
  assign idx       = addr_q[IDX_W+1:2];
  assign busy_wait = reset && (((state == S_IDLE) && request) || (state == S_ACCESS));

  always_comb begin
    aligned = 1'b1;
    case (func3_q[1:0])
      2'b01:   aligned = ~addr_q[0];
      2'b10:   aligned = (addr_q[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (write_q) legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010);
    else         legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010) ||
                         (func3_q == 3'b100) || (func3_q == 3'b101);
    error = ~legal | ~aligned;
  end

  always_comb begin
    word     = mem[idx];
    shifted  = word >> {addr_q[1:0], 3'b000};
    sel_half = addr_q[1] ? word[31:16] : word[15:0];
    case (func3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the enable mask alone picks the bytes.
  always_comb begin
    case (func3_q[1:0])
      2'b00: begin
        lane_data = {4{wdata_q[7:0]}};
        byte_en   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane_data = {2{wdata_q[15:0]}};
        byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = wdata_q;
        byte_en   = 4'b1111;
      end
    endcase
    for (int i = 0; i < 4; i++)
      merged[i*8 +: 8] = byte_en[i] ? lane_data[i*8 +: 8] : word[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      func3_q      <= 3'd0;
      write_q      <= 1'b0;
      read_data    <= 32'd0;
      access_error <= 1'b0;
    end else begin
      access_error <= commit && error;
      case (state)
        S_IDLE: begin
          if (request) begin
            addr_q  <= address;
            wdata_q <= write_data;
            func3_q <= func3;
            write_q <= mem_write;
            count   <= 4'(LATENCY - 1);
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (count == 4'd0) begin
            if (error)         read_data <= 32'd0;
            else if (!write_q) read_data <= load_val;
            state <= S_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && write_q && !error)
      mem[idx] <= merged;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a transaction-level model predicts
// busy_wait/read_data/access_error every cycle, plus literal checks per request.
module tb_data_memory_responder;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] read_data;
  logic        busy_wait;
  logic        access_error;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .func3(func3),
    .read_data(read_data), .busy_wait(busy_wait), .access_error(access_error)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a request accepted in cycle t0 completes in t0+L+1.
  logic [31:0] mem_m [256];
  int          cyc = 0;
  int          t0 = -10;
  int          done_at = -10;
  bit          p_write, p_err;
  logic [31:0] p_addr, p_wd;
  logic [2:0]  p_f3;
  logic [31:0] exp_rd = 32'd0;

  function automatic bit rule_err(bit wr, logic [31:0] a, logic [2:0] f);
    bit ok;
    if (wr) ok = (f == 0) || (f == 1) || (f == 2);
    else    ok = (f == 0) || (f == 1) || (f == 2) || (f == 4) || (f == 5);
    if ((f == 1 || f == 5) && (a % 2 != 0)) ok = 0;
    if (f == 2 && (a % 4 != 0)) ok = 0;
    return !ok;
  endfunction

  task automatic model_commit();
    int          idx, off;
    logic [31:0] w, b, h;
    idx = int'((p_addr >> 2) % 256);
    off = int'(p_addr % 4);
    w   = mem_m[idx];
    if (p_err) begin
      exp_rd = 32'd0;
    end else if (p_write) begin
      if (p_f3 == 0)      w[off*8 +: 8]  = p_wd[7:0];
      else if (p_f3 == 1) w[off*8 +: 16] = p_wd[15:0];
      else                w = p_wd;
      mem_m[idx] = w;
    end else begin
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * off)) & 32'hFFFF;
      case (p_f3)
        3'd0: exp_rd = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1: exp_rd = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd2: exp_rd = w;
        3'd4: exp_rd = b;
        default: exp_rd = h;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      t0 = -10;
      done_at = -10;
    end else begin
      if (cyc == done_at - 1) model_commit();
      if (cyc > done_at && (mem_read || mem_write)) begin
        t0      = cyc;
        done_at = cyc + L + 1;
        p_write = mem_write;
        p_addr  = address;
        p_wd    = write_data;
        p_f3    = func3;
        p_err   = rule_err(mem_write, address, func3);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit exp_busy, exp_err;
    if (!reset) begin
      t0 = -10;
      done_at = -10;
      exp_rd = 32'd0;
    end
    exp_busy = reset && ((cyc >= t0 && cyc < done_at) || (cyc > done_at && (mem_read || mem_write)));
    exp_err  = reset && (cyc == done_at) && p_err;
    n_tests += 3;
    if (busy_wait !== exp_busy) begin
      n_fail++;
      $display("FAIL model_busy cyc=%0d got=%b want=%b", cyc, busy_wait, exp_busy);
    end
    if (read_data !== exp_rd) begin
      n_fail++;
      $display("FAIL model_rdata cyc=%0d got=%h want=%h", cyc, read_data, exp_rd);
    end
    if (access_error !== exp_err) begin
      n_fail++;
      $display("FAIL model_err cyc=%0d got=%b want=%b", cyc, access_error, exp_err);
    end
  end

  task automatic txn(input string name, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f, input logic [31:0] want_rd,
                     input bit want_err);
    int busy_cnt = 0;
    bit done = 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; address = a; write_data = wd; func3 = f;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy_wait) busy_cnt++;
      else done = 1;
    end
    n_tests += 4;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout got=busy_stuck want=done", name);
    end
    if (busy_cnt != L + 1) begin
      n_fail++;
      $display("FAIL %s_busy_len got=%0d want=%0d", name, busy_cnt, L + 1);
    end
    if (read_data !== want_rd) begin
      n_fail++;
      $display("FAIL %s_rdata got=%h want=%h", name, read_data, want_rd);
    end
    if (access_error !== want_err) begin
      n_fail++;
      $display("FAIL %s_err got=%b want=%b", name, access_error, want_err);
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    txn("sw_10",   0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        0);
    txn("lw_10",   1, 0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 0);
    txn("lb_13",   1, 0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 0);
    txn("lbu_13",  1, 0, 32'h13, 32'h0,        3'd4, 32'h000000DE, 0);
    txn("lh_12",   1, 0, 32'h12, 32'h0,        3'd1, 32'hFFFFDEAD, 0);
    txn("lhu_10",  1, 0, 32'h10, 32'h0,        3'd5, 32'h0000BEEF, 0);
    txn("sb_11",   0, 1, 32'h11, 32'h55,       3'd0, 32'h0000BEEF, 0);
    txn("lw_sb",   1, 0, 32'h10, 32'h0,        3'd2, 32'hDEAD55EF, 0);
    txn("lb_11",   1, 0, 32'h11, 32'h0,        3'd0, 32'h00000055, 0);
    txn("sh_12",   0, 1, 32'h12, 32'h1234,     3'd1, 32'h00000055, 0);
    txn("lw_sh",   1, 0, 32'h10, 32'h0,        3'd2, 32'h123455EF, 0);
    txn("lw_mis",  1, 0, 32'h11, 32'h0,        3'd2, 32'h0,        1);
    txn("lw_ok",   1, 0, 32'h10, 32'h0,        3'd2, 32'h123455EF, 0);
    txn("sh_mis",  0, 1, 32'h13, 32'hFFFF,     3'd1, 32'h0,        1);
    txn("lw_kept", 1, 0, 32'h10, 32'h0,        3'd2, 32'h123455EF, 0);
    txn("ld_f3_3", 1, 0, 32'h10, 32'h0,        3'd3, 32'h0,        1);
    txn("st_f3_4", 0, 1, 32'h10, 32'h0,        3'd4, 32'h0,        1);
    txn("lw_ok2",  1, 0, 32'h10, 32'h0,        3'd2, 32'h123455EF, 0);
    txn("sw_20",   0, 1, 32'h20, 32'h11111111, 3'd2, 32'h123455EF, 0);

    // Reset during ACCESS of a store: outputs clear at once, store is dropped.
    @(posedge clk); #1;
    mem_write = 1; address = 32'h20; write_data = 32'hAAAAAAAA; func3 = 3'd2;
    @(posedge clk); #1;
    reset = 1'b0; mem_write = 0;
    @(negedge clk);
    n_tests += 2;
    if (busy_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got=%b want=0", busy_wait);
    end
    if (read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata got=%h want=00000000", read_data);
    end
    @(posedge clk); #1 reset = 1'b1;

    txn("lw_20",   1, 0, 32'h20,  32'h0, 3'd2, 32'h11111111, 0);
    txn("both_40", 1, 1, 32'h40,  32'h5, 3'd2, 32'h11111111, 0);
    txn("lw_40",   1, 0, 32'h40,  32'h0, 3'd2, 32'h00000005, 0);
    txn("lw_wrap", 1, 0, 32'h410, 32'h0, 3'd2, 32'h123455EF, 0);

    repeat (3) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the memory-access-stage load/store interface: accepts one read or write request from the MA stage and services it against an internal word-organised data array after a programmable latency.
- Holds busy_wait high to stall the pipeline until the access completes.
- Performs RV32 byte/half/word selection, sign/zero extension and store byte-lane merging from func3.
- Sits directly beside memory_access in the CPU top; read_data feeds the MA_WB register.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of 2.
- LATENCY, 3, cycles spent in ACCESS state; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request; held stable while busy_wait=1.
- mem_write  input  1  store request; held stable while busy_wait=1.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (rs2 value).
- func3  input  3  access size/sign.
- read_data  output  32  extended load result, registered.
- busy_wait  output  1  stall request to pipeline, combinational.
- access_error  output  1  one-cycle pulse on misaligned or illegal-func3 access.

Behaviour:
- States: IDLE, ACCESS, DONE. Encoding is free.
- busy_wait = (state==IDLE && (mem_read||mem_write)) || state==ACCESS. It is 0 in DONE and while reset is low.
- IDLE with a request at edge: latch address, write_data, func3, op (write wins if both mem_read and mem_write are high); load counter=LATENCY-1; go to ACCESS.
- ACCESS: counter decrements each edge. On the edge where counter==0:
  - commit the access (store into array, or capture the load into read_data);
  - go to DONE.
- DONE: lasts one cycle. read_data is valid, busy_wait=0, and the pipeline advances on this edge. Next state is IDLE unconditionally; a new request is seen from IDLE in the following cycle.
- Timing: a request first visible in cycle t0 gives busy_wait=1 in cycles t0..t0+LATENCY, and busy_wait=0 with data valid in t0+LATENCY+1.
- Word index = address[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (address wraps). Byte order is little-endian.
- Loads (func3): 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend. Byte lane = address[1:0]; half lane = address[1].
- Stores (func3): 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are modified; other bytes of the word are preserved.
- Misaligned access (half with address[0]=1, word with address[1:0]!=0) or illegal func3:
  - no array write; read_data=0;
  - access_error=1 for exactly the DONE cycle;
  - latency is unchanged.
- read_data holds its value until the next load completes. Stores do not change read_data.
- Reset (async, low):
  - state to IDLE; read_data=0, access_error=0, counter=0;
  - an in-flight store is aborted and not committed;
  - array contents are not cleared and hold whatever was written before reset.
- Request deasserted mid-ACCESS (protocol violation): the latched request still completes; no re-sample.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 (LATENCY=3) -> busy_wait high 4 cycles each; LW read_data=0xDEADBEEF in the DONE cycle.
- After that store, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF. SH 0x1234 to 0x12, then LW -> 0x123455EF.
- LW 0x11 -> access_error pulse 1 cycle, read_data=0. SH to 0x13 -> no change; LW 0x10 still 0x123455EF.
- Assert reset low mid-ACCESS of SW 0xAAAAAAAA to 0x20 (0x20 previously 0x11111111) -> busy_wait=0, read_data=0 immediately; after release LW 0x20 -> 0x11111111.
- mem_read and mem_write both high with address 0x40 and write_data 0x5 -> treated as store; following LW 0x40 -> 0x00000005. Also LW 0x410 with DEPTH_WORDS=256 -> returns the word at 0x010 (wrap).
